// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter with packet locking and a burst limit, sharing one uart_tx byte port
module uart_tx_arbiter #(
    parameter int NumPorts = 4,
    parameter int MaxBurst = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumPorts-1:0]   req_valid_i,
    output logic [NumPorts-1:0]   req_ready_o,
    input  logic [8*NumPorts-1:0] req_data_i,
    input  logic [NumPorts-1:0]   req_last_i,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic [7:0]            tx_data_o,
    output logic [NumPorts-1:0]   grant_o,
    output logic                  busy_o
);
    localparam int IdxW = $clog2(NumPorts);
    localparam int CntW = (MaxBurst > 0) ? $clog2(MaxBurst + 1) : 1;
    typedef enum logic {Idle, Locked} state_t;
    state_t          state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d, ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            found, xfer, rel;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        req_ready_o = '0;
        grant_o     = '0;
        busy_o      = 1'b0;
        found       = 1'b0;
        xfer        = 1'b0;
        rel         = 1'b0;
        if (state_q == Idle) begin
            for (int i = 0; i < NumPorts; i++) begin
                if (!found && req_valid_i[(int'(ptr_q) + i) % NumPorts]) begin
                    found   = 1'b1;
                    owner_d = IdxW'((int'(ptr_q) + i) % NumPorts);
                end
            end
            state_d = found ? Locked : Idle;
        end else begin
            busy_o               = 1'b1;
            grant_o[owner_q]     = 1'b1;
            tx_valid_o           = req_valid_i[owner_q];
            tx_data_o            = req_data_i[8*owner_q +: 8];
            req_ready_o[owner_q] = tx_ready_i;
            xfer                 = tx_valid_o & tx_ready_i;
            cnt_d                = (xfer && cnt_q != {CntW{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
            rel = xfer && (req_last_i[owner_q] || (MaxBurst != 0 && cnt_d == CntW'(MaxBurst)));
            if (rel) begin
                state_d = Idle;
                ptr_d   = IdxW'((int'(owner_q) + 1) % NumPorts);
                cnt_d   = '0;
            end
        end
    end
endmodule
